// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and sequencing controller for the five-stage pipeline.
// Decodes the D-stage (F/D) and X-stage (D/X) instructions. It drives the latch
// enables and bubble selects for load-use stalls, multdiv stalls and
// branch/jump flushes. It also runs the multdiv start/wait sequence and a
// saturating stall-cycle counter.
module pipeline_ctrl #(
  parameter int MD_CYCLES = 32
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [31:0] fd_ir,
  input  logic [31:0] dx_ir,
  input  logic        x_redirect,
  output logic        pc_en,
  output logic        fd_en,
  output logic        fd_nop,
  output logic        dx_en,
  output logic        dx_nop,
  output logic        xm_en,
  output logic        xm_nop,
  output logic        mw_en,
  output logic        md_start,
  output logic        md_busy,
  output logic [15:0] stall_count
);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  // BUSY counts down from here to zero, so start plus BUSY equals MD_CYCLES
  localparam logic [7:0] MD_LOAD  = 8'(MD_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdState_e;

  mdState_e    state_q, state_d;
  logic [7:0]  mdCnt_q, mdCnt_d;
  logic [15:0] stallCnt_q, stallCnt_d;

  logic [4:0] fdOp, fdRd, fdRs, fdRt;
  logic [4:0] dxOp, dxRd, dxAluop;
  logic       dxIsLw, dxIsMd, fdIsRtype, fdUsesRdField;
  logic       loadUse, mdStall, stallNow;
  logic       unused_ok;

  assign fdOp    = fd_ir[31:27];
  assign fdRd    = fd_ir[26:22];
  assign fdRs    = fd_ir[21:17];
  assign fdRt    = fd_ir[16:12];
  assign dxOp    = dx_ir[31:27];
  assign dxRd    = dx_ir[26:22];
  assign dxAluop = dx_ir[6:2];

  assign unused_ok = ^{fd_ir[11:0], dx_ir[21:7], dx_ir[1:0]};

  // Hazard decode: load-use between X and D, and mul/div sitting in X
  always_comb begin
    dxIsLw        = (dxOp == OP_LW);
    dxIsMd        = (dxOp == OP_RTYPE) && ((dxAluop == ALU_MUL) || (dxAluop == ALU_DIV));
    fdIsRtype     = (fdOp == OP_RTYPE);
    fdUsesRdField = (fdOp == OP_SW) || (fdOp == OP_BNE) || (fdOp == OP_BLT);
    loadUse       = dxIsLw && (dxRd != 5'd0) &&
                    ((fdRs == dxRd) ||
                     (fdIsRtype && (fdRt == dxRd)) ||
                     (fdUsesRdField && (fdRd == dxRd)));
    mdStall       = ((state_q == IDLE) && dxIsMd) || (state_q == BUSY);
    stallNow      = mdStall || (loadUse && !x_redirect);
  end

  // Latch control with priority multdiv stall, then redirect, then load-use
  always_comb begin
    pc_en    = 1'b1;
    fd_en    = 1'b1;
    fd_nop   = 1'b0;
    dx_en    = 1'b1;
    dx_nop   = 1'b0;
    xm_en    = 1'b1;
    xm_nop   = 1'b0;
    mw_en    = 1'b1;
    md_start = (state_q == IDLE) && dxIsMd;
    md_busy  = md_start || (state_q == BUSY) || (state_q == DONE);
    if (mdStall) begin
      pc_en  = 1'b0;
      fd_en  = 1'b0;
      dx_en  = 1'b0;
      xm_nop = 1'b1;
    end else if (x_redirect) begin
      fd_nop = 1'b1;
      dx_nop = 1'b1;
    end else if (loadUse) begin
      pc_en  = 1'b0;
      fd_en  = 1'b0;
      dx_nop = 1'b1;
    end
  end

  // Next state of the multdiv sequencer and the saturating stall counter
  always_comb begin
    state_d    = state_q;
    mdCnt_d    = mdCnt_q;
    stallCnt_d = stallCnt_q;
    case (state_q)
      IDLE: begin
        if (dxIsMd) begin
          state_d = BUSY;
          mdCnt_d = MD_LOAD;
        end
      end
      BUSY: begin
        if (mdCnt_q == 8'd0) begin
          state_d = DONE;
        end else begin
          mdCnt_d = mdCnt_q - 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (stallNow && (stallCnt_q != 16'hFFFF)) begin
      stallCnt_d = stallCnt_q + 16'd1;
    end
  end

  // State registers, cleared asynchronously by clr_n
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= IDLE;
      mdCnt_q    <= 8'd0;
      stallCnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      mdCnt_q    <= mdCnt_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  assign stall_count = stallCnt_q;

endmodule
